multicycle_control_unit: RTL and testbench

Parametrised multicycle successor to the single-cycle MIPS control unit. It decodes the instruction held in the datapath instruction register and drives a Moore FSM that sequences fetch, decode, execute, memory and writeback, with variable-latency handshakes to the instruction and data caches (ihit/dhit). It adds a configurable memory-wait watchdog and a sticky halt. It sits between the instruction register and the multicycle datapath; the datapath muxes and write enables are driven only from this block.

---
 rtl/multicycle_control_unit_if.sv | 53 +++++
 rtl/multicycle_control_unit.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and the datapath.
// master: the control unit (takes IR contents, cache hits and ALU zero;
//         drives memory requests, write enables, mux selects and status).
// slave : the datapath side, with the directions reversed.
// Signals:
//   instr           instruction register contents
//   ihit, dhit      instruction / data cache access complete
//   zero            ALU zero flag
//   iREN            instruction read request
//   dREN, dWEN      data read / write request
//   irWr, pcWr      instruction register and PC write enables
//   regWr           register-file write enable
//   alu_op, aluSrc  ALU operation and B-operand select
//   regDst, pcSrc   write-register and next-PC selects
//   extop, memtoreg immediate extension and write-back selects
//   halt, mem_err   sticky status
//   state           FSM state, for debug
interface multicycle_control_unit_if #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ALUOP_W = 4
);
  logic [WORD_W-1:0]  instr;
  logic               ihit;
  logic               dhit;
  logic               zero;
  logic               iREN;
  logic               dREN;
  logic               dWEN;
  logic               irWr;
  logic               pcWr;
  logic               regWr;
  logic [ALUOP_W-1:0] alu_op;
  logic               aluSrc;
  logic [1:0]         regDst;
  logic [1:0]         pcSrc;
  logic [1:0]         extop;
  logic [1:0]         memtoreg;
  logic               halt;
  logic               mem_err;
  logic [2:0]         state;

  modport master (
    input  instr, ihit, dhit, zero,
    output iREN, dREN, dWEN, irWr, pcWr, regWr, alu_op, aluSrc,
           regDst, pcSrc, extop, memtoreg, halt, mem_err, state
  );

  modport slave (
    output instr, ihit, dhit, zero,
    input  iREN, dREN, dWEN, irWr, pcWr, regWr, alu_op, aluSrc,
           regDst, pcSrc, extop, memtoreg, halt, mem_err, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit. Decodes the instruction register and sequences
// FETCH -> DECODE -> EXEC -> MEM -> WB with variable-latency cache handshakes,
// an optional wait watchdog (TIMEOUT cycles, 0 = off) and absorbing HALTED /
// ERROR states.
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous active-high reset
//   bus  control bus (master side), see multicycle_control_unit_if
module multicycle_control_unit #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned TIMEOUT = 0
) (
  input logic                       CLK,
  input logic                       RST,
  multicycle_control_unit_if.master bus
);

  // ALU operation encodings
  localparam logic [ALUOP_W-1:0] AluSll  = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] AluSrl  = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] AluSub  = ALUOP_W'(4'b0011);
  localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(4'b0100);
  localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(4'b0101);
  localparam logic [ALUOP_W-1:0] AluXor  = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] AluNor  = ALUOP_W'(4'b0111);
  localparam logic [ALUOP_W-1:0] AluSlt  = ALUOP_W'(4'b1010);
  localparam logic [ALUOP_W-1:0] AluSltu = ALUOP_W'(4'b1011);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpHalt  = 6'b111111;

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;

  localparam logic [1:0] ExtNone = 2'b00;
  localparam logic [1:0] ExtZero = 2'b01;
  localparam logic [1:0] ExtSign = 2'b10;
  localparam logic [1:0] ExtLui  = 2'b11;

  // Counter must be able to hold TIMEOUT itself.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] WaitLimit = CntW'(TIMEOUT);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalted = 3'd5,
    StError  = 3'd6
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   wait_q;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               is_r_alu, is_i_alu, is_lw, is_sw, is_beq, is_bne;
  logic               is_j, is_jal, is_jr, is_halt;
  logic [ALUOP_W-1:0] dec_aluop;
  logic [1:0]         dec_extop;
  logic               dec_alusrc;
  logic               wd_expired;
  logic               unused_instr;

  assign opcode       = bus.instr[WORD_W-1 -: 6];
  assign funct        = bus.instr[5:0];
  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_instr = ^bus.instr[WORD_W-7:6];

  always_comb begin
    is_r_alu  = 1'b0;
    is_i_alu  = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;
    is_jal    = 1'b0;
    is_jr     = 1'b0;
    is_halt   = 1'b0;
    dec_aluop = AluAdd;
    dec_extop = ExtNone;
    case (opcode)
      OpRtype: begin
        is_r_alu = 1'b1;
        case (funct)
          FnSll:          dec_aluop = AluSll;
          FnSrl:          dec_aluop = AluSrl;
          FnAdd, FnAddu:  dec_aluop = AluAdd;
          FnSub, FnSubu:  dec_aluop = AluSub;
          FnAnd:          dec_aluop = AluAnd;
          FnOr:           dec_aluop = AluOr;
          FnXor:          dec_aluop = AluXor;
          FnNor:          dec_aluop = AluNor;
          FnSlt:          dec_aluop = AluSlt;
          FnSltu:         dec_aluop = AluSltu;
          FnJr: begin
            is_r_alu = 1'b0;
            is_jr    = 1'b1;
          end
          default:        is_r_alu = 1'b0;
        endcase
      end
      OpJ:     is_j   = 1'b1;
      OpJal:   is_jal = 1'b1;
      OpBeq: begin
        is_beq    = 1'b1;
        dec_aluop = AluSub;
        dec_extop = ExtSign;
      end
      OpBne: begin
        is_bne    = 1'b1;
        dec_aluop = AluSub;
        dec_extop = ExtSign;
      end
      OpAddi, OpAddiu: begin
        is_i_alu  = 1'b1;
        dec_aluop = AluAdd;
        dec_extop = ExtSign;
      end
      OpSlti: begin
        is_i_alu  = 1'b1;
        dec_aluop = AluSlt;
        dec_extop = ExtSign;
      end
      OpSltiu: begin
        is_i_alu  = 1'b1;
        dec_aluop = AluSltu;
        dec_extop = ExtSign;
      end
      OpAndi: begin
        is_i_alu  = 1'b1;
        dec_aluop = AluAnd;
        dec_extop = ExtZero;
      end
      OpOri: begin
        is_i_alu  = 1'b1;
        dec_aluop = AluOr;
        dec_extop = ExtZero;
      end
      OpXori: begin
        is_i_alu  = 1'b1;
        dec_aluop = AluXor;
        dec_extop = ExtZero;
      end
      // LUI: shifted immediate ORed with $zero.
      OpLui: begin
        is_i_alu  = 1'b1;
        dec_aluop = AluOr;
        dec_extop = ExtLui;
      end
      OpLw: begin
        is_lw     = 1'b1;
        dec_aluop = AluAdd;
        dec_extop = ExtSign;
      end
      OpSw: begin
        is_sw     = 1'b1;
        dec_aluop = AluAdd;
        dec_extop = ExtSign;
      end
      OpHalt:  is_halt = 1'b1;
      default: ;
    endcase
  end

  // Branches compare two registers, so only ALU immediates and memory ops use imm.
  assign dec_alusrc = is_i_alu | is_lw | is_sw;
  assign wd_expired = (TIMEOUT != 0) && (wait_q == WaitLimit);

  // Wait counter is cleared by default on every cycle and only advanced while
  // FETCH or MEM keeps waiting, so it is zero on every entry to those states.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      wait_q <= '0;
      case (state_q)
        StFetch: begin
          if (bus.ihit) begin
            state_q <= StDecode;
          end else if (wd_expired) begin
            state_q <= StError;
          end else begin
            wait_q <= wait_q + CntW'(1);
          end
        end
        StDecode: begin
          if (is_halt) begin
            state_q <= StHalted;
          end else if (is_jal) begin
            state_q <= StWb;
          end else if (is_r_alu | is_i_alu | is_lw | is_sw | is_beq | is_bne) begin
            state_q <= StExec;
          end else begin
            // J, JR and undefined encodings all return to fetch.
            state_q <= StFetch;
          end
        end
        StExec: begin
          if (is_lw | is_sw) begin
            state_q <= StMem;
          end else if (is_r_alu | is_i_alu) begin
            state_q <= StWb;
          end else begin
            state_q <= StFetch;
          end
        end
        StMem: begin
          if (bus.dhit) begin
            state_q <= is_lw ? StWb : StFetch;
          end else if (wd_expired) begin
            state_q <= StError;
          end else begin
            wait_q <= wait_q + CntW'(1);
          end
        end
        StWb:     state_q <= StFetch;
        StHalted: state_q <= StHalted;
        StError:  state_q <= StError;
        default:  state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.irWr     = 1'b0;
    bus.pcWr     = 1'b0;
    bus.regWr    = 1'b0;
    bus.alu_op   = '0;
    bus.aluSrc   = 1'b0;
    bus.regDst   = 2'b00;
    bus.pcSrc    = 2'b00;
    bus.extop    = 2'b00;
    bus.memtoreg = 2'b00;
    bus.halt     = 1'b0;
    bus.mem_err  = 1'b0;
    bus.state    = state_q;
    case (state_q)
      StFetch: begin
        bus.iREN = 1'b1;
        if (bus.ihit) begin
          bus.irWr = 1'b1;
          bus.pcWr = 1'b1;
        end
      end
      StDecode: begin
        if (is_j) begin
          bus.pcWr  = 1'b1;
          bus.pcSrc = 2'b10;
        end else if (is_jr) begin
          bus.pcWr  = 1'b1;
          bus.pcSrc = 2'b01;
        end
      end
      StExec: begin
        bus.alu_op = dec_aluop;
        bus.aluSrc = dec_alusrc;
        bus.extop  = dec_extop;
        if (is_beq | is_bne) begin
          bus.pcSrc = 2'b11;
          bus.pcWr  = is_beq ? bus.zero : ~bus.zero;
        end
      end
      StMem: begin
        bus.dREN = is_lw;
        bus.dWEN = is_sw;
      end
      StWb: begin
        bus.regWr = 1'b1;
        if (is_jal) begin
          bus.regDst   = 2'b11;
          bus.memtoreg = 2'b10;
          bus.pcWr     = 1'b1;
          bus.pcSrc    = 2'b10;
        end else if (is_lw) begin
          bus.regDst   = 2'b01;
          bus.memtoreg = 2'b01;
        end else if (is_i_alu) begin
          bus.regDst   = 2'b01;
        end
      end
      StHalted: bus.halt    = 1'b1;
      StError:  bus.mem_err = 1'b1;
      default:  ;
    endcase
    // Reset must never let a write reach the datapath or memory.
    if (RST) begin
      bus.irWr  = 1'b0;
      bus.pcWr  = 1'b0;
      bus.regWr = 1'b0;
      bus.dWEN  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (TIMEOUT = 4). Each scenario
// schedules per-cycle stimulus and pushes the expected outputs to a scoreboard
// queue; the queue is popped and compared after each cycle is driven.
module tb_multicycle_control_unit;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SX = 3'd2, SM = 3'd3;
  localparam logic [2:0] SW = 3'd4, SH = 3'd5, SE = 3'd6;
  localparam logic [3:0] A_SLL = 4'd0, A_ADD = 4'd2, A_SUB = 4'd3, A_OR = 4'd5;
  localparam logic [3:0] A_NOR = 4'd7, A_SLT = 4'd10;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220008;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_HALT = 32'hFC000000;

  // en = {iREN, dREN, dWEN, irWr, pcWr, regWr}; hm = {halt, mem_err}
  typedef struct packed {
    logic [2:0] st;
    logic [5:0] en;
    logic [3:0] aop;
    logic       asrc;
    logic [1:0] rd;
    logic [1:0] ps;
    logic [1:0] eo;
    logic [1:0] mr;
    logic [1:0] hm;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] ins;
    logic        ih;
    logic        dh;
    logic        z;
  } stim_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_total = 0;
  int   n_bad   = 0;
  exp_t  q[$];
  stim_t sq[$];
  logic [23:0] obs;

  always #5 CLK = ~CLK;

  multicycle_control_unit_if #(.WORD_W(32), .ALUOP_W(4)) bus ();

  multicycle_control_unit #(.WORD_W(32), .ALUOP_W(4), .TIMEOUT(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  assign obs = {bus.state, bus.iREN, bus.dREN, bus.dWEN, bus.irWr, bus.pcWr, bus.regWr,
                bus.alu_op, bus.aluSrc, bus.regDst, bus.pcSrc, bus.extop, bus.memtoreg,
                bus.halt, bus.mem_err};

  function automatic exp_t ex(input logic [2:0] st, input logic [5:0] en,
                              input logic [3:0] aop, input logic asrc,
                              input logic [1:0] rd, input logic [1:0] ps,
                              input logic [1:0] eo, input logic [1:0] mr,
                              input logic [1:0] hm);
    exp_t e;
    e.st = st; e.en = en; e.aop = aop; e.asrc = asrc; e.rd = rd;
    e.ps = ps; e.eo = eo; e.mr = mr; e.hm = hm;
    return e;
  endfunction

  function automatic exp_t x_idle();
    return ex(SF, 6'b100000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic exp_t x_hit();
    return ex(SF, 6'b100110, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic exp_t x_dec();
    return ex(SD, 6'b000000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic exp_t x_exec(input logic [3:0] aop, input logic asrc, input logic [1:0] eo);
    return ex(SX, 6'b000000, aop, asrc, 2'b00, 2'b00, eo, 2'b00, 2'b00);
  endfunction
  function automatic exp_t x_wb(input logic [1:0] rd, input logic [1:0] mr);
    return ex(SW, 6'b000001, 4'd0, 1'b0, rd, 2'b00, 2'b00, mr, 2'b00);
  endfunction
  function automatic exp_t x_err();
    return ex(SE, 6'b000000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
  endfunction
  function automatic exp_t x_halt();
    return ex(SH, 6'b000000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
  endfunction

  function automatic stim_t sti(input logic rst, input logic [31:0] ins,
                                input logic ih, input logic dh, input logic z);
    stim_t s;
    s.rst = rst; s.ins = ins; s.ih = ih; s.dh = dh; s.z = z;
    return s;
  endfunction

  task automatic cyc(input stim_t s, input exp_t e);
    sq.push_back(s);
    q.push_back(e);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input stim_t s);
    @(negedge CLK);
    RST      = s.rst;
    bus.instr = s.ins;
    bus.ihit = s.ih;
    bus.dhit = s.dh;
    bus.zero = s.z;
    #1;
  endtask

  task automatic test_reset();
    exp_t want; int k = 0;
    cyc(sti(1'b1, I_ADD, 1'b1, 1'b0, 1'b0), x_idle());
    cyc(sti(1'b1, I_ADD, 1'b1, 1'b0, 1'b0), x_idle());
    cyc(sti(1'b0, I_ADD, 1'b0, 1'b0, 1'b0), x_idle());
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_add();
    exp_t want; int k = 0;
    cyc(sti(1'b0, I_ADD, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_ADD, 1'b0, 1'b0, 1'b0), x_dec());
    cyc(sti(1'b0, I_ADD, 1'b0, 1'b0, 1'b0), x_exec(A_ADD, 1'b0, 2'b00));
    cyc(sti(1'b0, I_ADD, 1'b0, 1'b0, 1'b0), x_wb(2'b00, 2'b00));
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL add cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_alu();
    exp_t want; int k = 0;
    logic [31:0] ins [6];
    logic [3:0]  aop [6];
    logic        asr [6];
    logic [1:0]  eo  [6];
    logic [1:0]  rd  [6];
    ins = '{32'h00221822, 32'h00021080, 32'h00221827, 32'h34220055, 32'h3C021234, 32'h2822FFFF};
    aop = '{A_SUB, A_SLL, A_NOR, A_OR, A_OR, A_SLT};
    asr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    eo  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
    rd  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 6; i++) begin
      cyc(sti(1'b0, ins[i], 1'b1, 1'b0, 1'b0), x_hit());
      cyc(sti(1'b0, ins[i], 1'b0, 1'b0, 1'b0), x_dec());
      cyc(sti(1'b0, ins[i], 1'b0, 1'b0, 1'b0), x_exec(aop[i], asr[i], eo[i]));
      cyc(sti(1'b0, ins[i], 1'b0, 1'b0, 1'b0), x_wb(rd[i], 2'b00));
    end
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL alu cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_lw_wait();
    exp_t want; int k = 0;
    cyc(sti(1'b0, I_LW, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_LW, 1'b0, 1'b0, 1'b0), x_dec());
    cyc(sti(1'b0, I_LW, 1'b0, 1'b0, 1'b0), x_exec(A_ADD, 1'b1, 2'b10));
    for (int i = 0; i < 3; i++) begin
      cyc(sti(1'b0, I_LW, 1'b0, (i == 2), 1'b0),
          ex(SM, 6'b010000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    end
    cyc(sti(1'b0, I_LW, 1'b0, 1'b0, 1'b0), x_wb(2'b01, 2'b01));
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL lw_wait cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_sw();
    exp_t want; int k = 0;
    cyc(sti(1'b0, I_SW, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_SW, 1'b0, 1'b0, 1'b0), x_dec());
    cyc(sti(1'b0, I_SW, 1'b0, 1'b0, 1'b0), x_exec(A_ADD, 1'b1, 2'b10));
    cyc(sti(1'b0, I_SW, 1'b0, 1'b1, 1'b0),
        ex(SM, 6'b001000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL sw cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_branch();
    exp_t want; int k = 0;
    logic [31:0] ins [3];
    logic        z   [3];
    logic [5:0]  en  [3];
    ins = '{I_BEQ, I_BNE, I_BNE};
    z   = '{1'b1, 1'b1, 1'b0};
    en  = '{6'b000010, 6'b000000, 6'b000010};
    for (int i = 0; i < 3; i++) begin
      cyc(sti(1'b0, ins[i], 1'b1, 1'b0, z[i]), x_hit());
      cyc(sti(1'b0, ins[i], 1'b0, 1'b0, z[i]), x_dec());
      cyc(sti(1'b0, ins[i], 1'b0, 1'b0, z[i]),
          ex(SX, en[i], A_SUB, 1'b0, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00));
    end
    cyc(sti(1'b0, I_ADD, 1'b0, 1'b0, 1'b0), x_idle());
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL branch cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_jumps();
    exp_t want; int k = 0;
    cyc(sti(1'b0, I_J, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_J, 1'b0, 1'b0, 1'b0),
        ex(SD, 6'b000010, 4'd0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));
    cyc(sti(1'b0, I_JR, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_JR, 1'b0, 1'b0, 1'b0),
        ex(SD, 6'b000010, 4'd0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    cyc(sti(1'b0, I_JAL, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_JAL, 1'b0, 1'b0, 1'b0), x_dec());
    cyc(sti(1'b0, I_JAL, 1'b0, 1'b0, 1'b0),
        ex(SW, 6'b000011, 4'd0, 1'b0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00));
    // Undefined opcode, then undefined R-type funct: straight back to fetch.
    cyc(sti(1'b0, 32'h70000000, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, 32'h70000000, 1'b0, 1'b0, 1'b0), x_dec());
    cyc(sti(1'b0, 32'h0000003F, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, 32'h0000003F, 1'b0, 1'b0, 1'b0), x_dec());
    cyc(sti(1'b0, 32'h0000003F, 1'b0, 1'b0, 1'b0), x_idle());
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL jumps cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_timeout();
    exp_t want; int k = 0;
    cyc(sti(1'b1, I_J, 1'b0, 1'b0, 1'b0), x_idle());
    for (int i = 0; i < 5; i++) cyc(sti(1'b0, I_J, 1'b0, 1'b0, 1'b0), x_idle());
    for (int i = 0; i < 3; i++) cyc(sti(1'b0, I_J, 1'b1, 1'b1, 1'b1), x_err());
    cyc(sti(1'b1, I_J, 1'b0, 1'b0, 1'b0), x_err());
    // Hit on the limit cycle wins over the watchdog.
    for (int i = 0; i < 4; i++) cyc(sti(1'b0, I_J, 1'b0, 1'b0, 1'b0), x_idle());
    cyc(sti(1'b0, I_J, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_J, 1'b0, 1'b0, 1'b0),
        ex(SD, 6'b000010, 4'd0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));
    // Fetch waits must not shorten the later MEM wait budget.
    for (int i = 0; i < 3; i++) cyc(sti(1'b0, I_LW, 1'b0, 1'b0, 1'b0), x_idle());
    cyc(sti(1'b0, I_LW, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_LW, 1'b0, 1'b0, 1'b0), x_dec());
    cyc(sti(1'b0, I_LW, 1'b0, 1'b0, 1'b0), x_exec(A_ADD, 1'b1, 2'b10));
    for (int i = 0; i < 5; i++) begin
      cyc(sti(1'b0, I_LW, 1'b0, 1'b0, 1'b0),
          ex(SM, 6'b010000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    end
    for (int i = 0; i < 2; i++) cyc(sti(1'b0, I_LW, 1'b0, 1'b1, 1'b0), x_err());
    cyc(sti(1'b1, I_LW, 1'b0, 1'b0, 1'b0), x_err());
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL timeout cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_halt();
    exp_t want; int k = 0;
    cyc(sti(1'b0, I_HALT, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_HALT, 1'b0, 1'b0, 1'b0), x_dec());
    for (int i = 0; i < 10; i++) cyc(sti(1'b0, I_ADD, 1'b1, 1'b1, 1'b1), x_halt());
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL halt cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_mem();
    exp_t want; int k = 0;
    cyc(sti(1'b1, I_SW, 1'b0, 1'b0, 1'b0), x_halt());
    cyc(sti(1'b0, I_SW, 1'b1, 1'b0, 1'b0), x_hit());
    cyc(sti(1'b0, I_SW, 1'b0, 1'b0, 1'b0), x_dec());
    cyc(sti(1'b0, I_SW, 1'b0, 1'b0, 1'b0), x_exec(A_ADD, 1'b1, 2'b10));
    cyc(sti(1'b0, I_SW, 1'b0, 1'b0, 1'b0),
        ex(SM, 6'b001000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    cyc(sti(1'b1, I_SW, 1'b0, 1'b0, 1'b0),
        ex(SM, 6'b000000, 4'd0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    cyc(sti(1'b0, I_SW, 1'b0, 1'b0, 1'b0), x_idle());
    while (sq.size() != 0) begin
      step(sq.pop_front());
      want = q.pop_front();
      n_total++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL reset_mid_mem cyc=%0d got=%h want=%h", k, obs, want);
      end
      k++;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL time_limit elapsed got=running want=finished");
    $fatal(1, "time limit");
  end

  initial begin
    RST       = 1'b1;
    bus.instr = 32'h0;
    bus.ihit  = 1'b0;
    bus.dhit  = 1'b0;
    bus.zero  = 1'b0;
    test_reset();
    test_add();
    test_alu();
    test_lw_wait();
    test_sw();
    test_branch();
    test_jumps();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
